// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream_if
//  Description : Bundle between the FIFO read stage, its memory and the
//                downstream valid/ready consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            level;

  // Streaming block side: issues reads, presents words downstream
  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data, level
  );

  // Environment side: read-pointer stage, memory and consumer
  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, level
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Turns a FIFO read port with one-cycle read latency into a
//                valid/ready stream using a 2-entry skid buffer and a
//                credit-based read request.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic       rclk,
  input  wire logic       rrst_n,
  fifo_rd_stream_if.master bus
);

  localparam logic [2:0] c_CREDITS = 3'd2;

  logic [DATA_WIDTH-1:0] r_buf0;   // oldest word, drives m_data
  logic [DATA_WIDTH-1:0] r_buf1;   // second word
  logic [1:0]            r_level;
  logic                  r_pend;   // read issued last cycle, rdata valid now

  logic                  w_pop;
  logic [2:0]            w_occupancy;

  // Credit check: a new read may be issued only if, after this cycle's pop,
  // the words buffered plus the one in flight leave room for one more.
  always_comb begin
    w_pop       = bus.m_valid & bus.m_ready;
    w_occupancy = {1'b0, r_level} + {2'b00, r_pend} - {2'b00, w_pop};
    bus.rinc    = rrst_n & ~bus.rempty & (w_occupancy < c_CREDITS);
  end

  assign bus.m_valid = (r_level != 2'd0);
  assign bus.m_data  = r_buf0;
  assign bus.level   = r_level;

  // Buffer, level and in-flight tracking; capture and pop may coincide
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_level <= 2'd0;
      r_pend  <= 1'b0;
    end else begin
      // rinc already folds in rempty, so it marks an issued read
      r_pend <= bus.rinc;
      case ({r_pend, w_pop})
        2'b10: begin
          if (r_level == 2'd0) r_buf0 <= bus.rdata;
          else                 r_buf1 <= bus.rdata;
          r_level <= r_level + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_level <= r_level - 2'd1;
        end
        2'b11: begin
          // Level is unchanged; the incoming word lands behind whatever
          // remains after the head leaves.
          if (r_level == 2'd1) begin
            r_buf0 <= bus.rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stream
//  Description : Self-checking bench for fifo_rd_stream with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  localparam int DATA_WIDTH = 8;

  logic rclk;
  logic rrst_n;

  fifo_rd_stream_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words in the output buffer plus one word in flight
  logic [DATA_WIDTH-1:0] mdl_q[$];
  logic                  mdl_pend;
  logic [DATA_WIDTH-1:0] pend_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic [DATA_WIDTH-1:0] last_out;
  int                    n_iss;
  int                    n_out;
  int                    lvl_max;
  int                    rinc_cnt;
  bit                    want_first;
  logic [DATA_WIDTH-1:0] first_out;
  bit                    got_first;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, check outputs, advance model at posedge
  task automatic step(input logic rst_n_i, input logic empty_i, input logic ready_i);
    bit exp_pop;
    bit exp_rinc;
    bit dut_issue;
    int occ;
    rrst_n      = rst_n_i;
    bus.rempty  = empty_i;
    bus.m_ready = ready_i;
    #1;
    exp_pop  = ready_i && (mdl_q.size() != 0);
    occ      = mdl_q.size() + int'(mdl_pend) - int'(exp_pop);
    exp_rinc = rst_n_i && !empty_i && (occ < 2);
    check_val("rinc", 32'(bus.rinc), 32'(exp_rinc));
    check_val("m_valid", 32'(bus.m_valid), 32'(mdl_q.size() != 0));
    check_val("level", 32'(bus.level), 32'(mdl_q.size()));
    if (mdl_q.size() != 0) check_val("m_data", 32'(bus.m_data), 32'(mdl_q[0]));
    if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
    if (bus.rinc) rinc_cnt++;
    dut_issue = bus.rinc && !bus.rempty;
    @(posedge rclk);
    if (!rst_n_i) begin
      mdl_q.delete();
      mdl_pend = 1'b0;
    end else begin
      if (exp_pop) begin
        last_out = mdl_q.pop_front();
        n_out++;
        if (want_first) begin
          want_first = 1'b0;
          got_first  = 1'b1;
          first_out  = last_out;
        end
      end
      if (mdl_pend) mdl_q.push_back(pend_word);
      mdl_pend = exp_rinc;
      if (exp_rinc) n_iss++;
    end
    #1;
    // Memory: read data appears one cycle after the read that fetched it
    if (dut_issue) begin
      bus.rdata = next_word;
      pend_word = next_word;
      next_word = next_word + 1'b1;
    end else begin
      bus.rdata = DATA_WIDTH'($urandom);
    end
    @(negedge rclk);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic clear_counts();
    n_iss = 0; n_out = 0; lvl_max = 0; rinc_cnt = 0;
  endtask

  initial begin
    rrst_n      = 1'b0;
    bus.rempty  = 1'b0;
    bus.m_ready = 1'b0;
    bus.rdata   = '0;
    mdl_pend    = 1'b0;
    pend_word   = '0;
    next_word   = '0;
    last_out    = '0;
    want_first  = 1'b0;
    got_first   = 1'b0;
    first_out   = '0;
    clear_counts();
    @(negedge rclk);

    // Reset held two cycles with data available
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #1;
    check_val("rst_m_data", 32'(bus.m_data), 32'h0);
    check_val("rst_level", 32'(bus.level), 32'h0);

    // Single word 0xA5
    clear_counts();
    next_word = 8'hA5;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
    check_val("single_rinc_pulses", 32'(rinc_cnt), 32'd1);
    check_val("single_outs", 32'(n_out), 32'd1);
    check_val("single_word", 32'(last_out), 32'hA5);

    // Streaming 0x01..0x10
    clear_counts();
    next_word = 8'h01;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1);
    drain();
    check_val("stream_rinc_cnt", 32'(rinc_cnt), 32'd16);
    check_val("stream_outs", 32'(n_out), 32'd16);
    check_val("stream_last", 32'(last_out), 32'h10);
    check_val("stream_lvl_max", 32'(lvl_max <= 1), 32'd1);

    // Backpressure for five cycles mid-stream
    clear_counts();
    next_word = 8'h20;
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    drain();
    check_val("bp_lvl_max", 32'(lvl_max), 32'd2);
    check_val("bp_no_loss", 32'(n_out), 32'(n_iss));
    check_val("bp_last", 32'(last_out), 32'(next_word - 1'b1));

    // rempty toggling every cycle
    clear_counts();
    for (int i = 0; i < 20; i++) step(1'b1, logic'(i & 1), 1'b1);
    drain();
    check_val("toggle_issues", 32'(n_iss), 32'd10);
    check_val("toggle_outs", 32'(n_out), 32'(n_iss));

    // Random traffic
    clear_counts();
    for (int i = 0; i < 400; i++)
      step(1'b1, logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) != 0));
    drain();
    check_val("rand_outs", 32'(n_out), 32'(n_iss));

    // Reset with a word buffered and a read in flight
    clear_counts();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check_val("pre_rst_level", 32'(bus.level), 32'd1);
    check_val("pre_rst_rinc", 32'(bus.rinc), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    #1;
    check_val("post_rst_level", 32'(bus.level), 32'd0);
    check_val("post_rst_m_data", 32'(bus.m_data), 32'h0);
    want_first = 1'b1;
    first_out  = '0;
    got_first  = 1'b0;
    begin
      logic [DATA_WIDTH-1:0] exp_first;
      exp_first = next_word;
      for (int i = 0; i < 10 && !got_first; i++) step(1'b1, 1'b0, 1'b1);
      check_val("post_rst_first_seen", 32'(got_first), 32'd1);
      check_val("post_rst_first_word", 32'(first_out), 32'(exp_first));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
